// File: rtl/delay_pipe.sv
// delay_pipe: elastic DELAY-stage delay line with a valid bit per stage.
//
// Words enter through a valid/ready handshake and leave from the last
// stage through another.  With COLLAPSE=1 each stage advances on its own,
// so empty stages (bubbles) are squeezed out while the output stalls.
// With COLLAPSE=0 the whole chain shifts together whenever the last stage
// can move, which matches a plain enable-driven delay line.
// DELAY=0 degenerates to a combinational wire-through.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset (clears valid and data)
//   flush      synchronous clear of every stage valid bit
//   in_valid   upstream word valid
//   in_ready   word on in_data is accepted this cycle
//   in_data    upstream word
//   out_valid  last stage holds a word
//   out_ready  downstream accepts out_data
//   out_data   data of the last stage
//   occupancy  number of valid stages (registered)

module delay_pipe #(
    parameter int DELAY    = 4,
    parameter int WIDTH    = 16,
    parameter int COLLAPSE = 1,
    localparam int OCC_W   = (DELAY < 1) ? 1 : $clog2(DELAY + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
);

    if (DELAY == 0) begin : g_pass
        assign in_ready  = out_ready;
        assign out_valid = in_valid;
        assign out_data  = in_data;
        assign occupancy = '0;

        // Clock, reset and flush have nothing to act on without stages.
        logic unused_ctl;
        assign unused_ctl = ^{clk, rst, flush};
    end else begin : g_pipe
        logic             v   [DELAY];
        logic [WIDTH-1:0] d   [DELAY];
        logic             vin [DELAY];
        logic [WIDTH-1:0] din [DELAY];
        logic [DELAY-1:0] ld;
        logic             can_take;
        logic             in_fire;
        logic             out_fire;

        // Each stage's source: the upstream port for stage 0, else the
        // previous stage.
        always_comb begin
            vin[0] = in_valid;
            din[0] = in_data;
            for (int unsigned i = 1; i < DELAY; i++) begin
                vin[i] = v[i-1];
                din[i] = d[i-1];
            end
        end

        if (COLLAPSE != 0) begin : g_collapse
            // r[i]: stage i may load this cycle. A stage is free when it is
            // empty or its successor is moving, chained back from out_ready.
            logic [DELAY:0] r;
            always_comb begin
                r[DELAY] = out_ready;
                for (int unsigned i = DELAY; i > 0; i--) begin
                    r[i-1] = !v[i-1] || r[i];
                end
            end
            assign ld       = r[DELAY-1:0];
            assign can_take = r[0];
        end else begin : g_global
            logic adv;
            assign adv      = out_ready || !v[DELAY-1];
            assign ld       = {DELAY{adv}};
            assign can_take = adv;
        end

        assign in_ready  = can_take && !flush;
        assign out_valid = v[DELAY-1];
        assign out_data  = d[DELAY-1];
        assign in_fire   = in_valid && in_ready;
        assign out_fire  = out_valid && out_ready;

        // Data only moves behind a valid word when collapsing, so a stage
        // that swallows a bubble keeps its previous contents.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int unsigned i = 0; i < DELAY; i++) begin
                    v[i] <= 1'b0;
                    d[i] <= '0;
                end
            end else if (flush) begin
                for (int unsigned i = 0; i < DELAY; i++) begin
                    v[i] <= 1'b0;
                end
            end else begin
                for (int unsigned i = 0; i < DELAY; i++) begin
                    if (ld[i]) begin
                        v[i] <= vin[i];
                        if (vin[i] || (COLLAPSE == 0)) begin
                            d[i] <= din[i];
                        end
                    end
                end
            end
        end

        // Tracked as a transfer counter; equals the popcount of v.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                occupancy <= '0;
            end else if (flush) begin
                occupancy <= '0;
            end else begin
                occupancy <= occupancy + OCC_W'(in_fire) - OCC_W'(out_fire);
            end
        end
    end

endmodule

// File: tb/tb_delay_pipe.sv
// tb_delay_pipe: self-checking bench for delay_pipe.
//
// Instances: u0 (DELAY=4, COLLAPSE=1), u1 (DELAY=4, COLLAPSE=0),
// u2 (DELAY=1, COLLAPSE=1), u3 (DELAY=0).  A reference model keeps each
// pipe as an ordered list of words with their stage positions and is
// compared against the DUTs on every falling edge.

module tb_delay_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0]  iv, ordy, fl;
    logic [15:0] id [3];
    logic [2:0]  ir_d, ov_d;
    logic [15:0] od_d [3];
    logic [2:0]  occ0, occ1;
    logic [0:0]  occ2;

    logic        iv3, ordy3, fl3, ir3, ov3;
    logic [15:0] id3, od3;
    logic [0:0]  occ3;

    delay_pipe #(.DELAY(4), .WIDTH(16), .COLLAPSE(1)) u0 (
        .clk(clk), .rst(rst), .flush(fl[0]), .in_valid(iv[0]), .in_ready(ir_d[0]),
        .in_data(id[0]), .out_valid(ov_d[0]), .out_ready(ordy[0]), .out_data(od_d[0]),
        .occupancy(occ0));
    delay_pipe #(.DELAY(4), .WIDTH(16), .COLLAPSE(0)) u1 (
        .clk(clk), .rst(rst), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir_d[1]),
        .in_data(id[1]), .out_valid(ov_d[1]), .out_ready(ordy[1]), .out_data(od_d[1]),
        .occupancy(occ1));
    delay_pipe #(.DELAY(1), .WIDTH(16), .COLLAPSE(1)) u2 (
        .clk(clk), .rst(rst), .flush(fl[2]), .in_valid(iv[2]), .in_ready(ir_d[2]),
        .in_data(id[2]), .out_valid(ov_d[2]), .out_ready(ordy[2]), .out_data(od_d[2]),
        .occupancy(occ2));
    delay_pipe #(.DELAY(0), .WIDTH(16), .COLLAPSE(1)) u3 (
        .clk(clk), .rst(rst), .flush(fl3), .in_valid(iv3), .in_ready(ir3),
        .in_data(id3), .out_valid(ov3), .out_ready(ordy3), .out_data(od3),
        .occupancy(occ3));

    int ncmp = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        ncmp++;
        if (act !== want) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, want, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Words per pipe, oldest first, with the stage index each occupies.
    int          mcnt [3];
    int          mpos [3][8];
    logic [15:0] mdat [3][8];
    logic [2:0]  acc;

    function automatic int dly_of(input int k);
        return (k == 2) ? 1 : 4;
    endfunction

    function automatic bit col_of(input int k);
        return (k != 1);
    endfunction

    function automatic logic [31:0] occ_of(input int k);
        case (k)
            0:       return 32'(occ0);
            1:       return 32'(occ1);
            default: return 32'(occ2);
        endcase
    endfunction

    // Collapsing: the oldest word may advance up to the output (and leave
    // when out_ready); every younger word may advance at most to just
    // behind where the word ahead of it ends up.  A new word fits when
    // stage 0 is left free.  Global stall: everything shifts when the last
    // stage is empty or draining.
    function automatic bit m_in_ready(input int k, input bit ordy_i, input bit fl_i);
        int cap;
        int np;
        if (fl_i) return 1'b0;
        if (col_of(k)) begin
            cap = ordy_i ? dly_of(k) : dly_of(k) - 1;
            for (int j = 0; j < mcnt[k]; j++) begin
                np  = (mpos[k][j] + 1 < cap) ? mpos[k][j] + 1 : cap;
                cap = np - 1;
            end
            return cap >= 0;
        end
        return ordy_i || !(mcnt[k] > 0 && mpos[k][0] == dly_of(k) - 1);
    endfunction

    task automatic m_step(input int k, input bit iv_i, input logic [15:0] dat_i,
                          input bit ordy_i, input bit fl_i);
        bit irdy;
        int cap;
        int np;
        if (fl_i) begin
            mcnt[k] = 0;
            return;
        end
        irdy = m_in_ready(k, ordy_i, 1'b0);
        if (col_of(k)) begin
            cap = ordy_i ? dly_of(k) : dly_of(k) - 1;
            for (int j = 0; j < mcnt[k]; j++) begin
                np         = (mpos[k][j] + 1 < cap) ? mpos[k][j] + 1 : cap;
                mpos[k][j] = np;
                cap        = np - 1;
            end
        end else if (irdy) begin
            for (int j = 0; j < mcnt[k]; j++) mpos[k][j] = mpos[k][j] + 1;
        end
        if (mcnt[k] > 0 && mpos[k][0] == dly_of(k)) begin
            for (int j = 1; j < mcnt[k]; j++) begin
                mpos[k][j-1] = mpos[k][j];
                mdat[k][j-1] = mdat[k][j];
            end
            mcnt[k]--;
        end
        if (iv_i && irdy) begin
            mpos[k][mcnt[k]] = 0;
            mdat[k][mcnt[k]] = dat_i;
            mcnt[k]++;
        end
    endtask

    // ---------------- compare process ----------------
    logic exp_ir, exp_ov;
    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                mcnt[k] = 0;
                acc[k]  = 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                exp_ir = m_in_ready(k, ordy[k], fl[k]);
                exp_ov = (mcnt[k] > 0) && (mpos[k][0] == dly_of(k) - 1);
                chk($sformatf("u%0d_in_ready", k), 32'(ir_d[k]), 32'(exp_ir));
                chk($sformatf("u%0d_out_valid", k), 32'(ov_d[k]), 32'(exp_ov));
                if (exp_ov) chk($sformatf("u%0d_out_data", k), 32'(od_d[k]), 32'(mdat[k][0]));
                chk($sformatf("u%0d_occupancy", k), occ_of(k), 32'(mcnt[k]));
                acc[k] = iv[k] && exp_ir;
                m_step(k, iv[k], id[k], ordy[k], fl[k]);
            end
            chk("u3_out_valid", 32'(ov3), 32'(iv3));
            chk("u3_out_data", 32'(od3), 32'(id3));
            chk("u3_in_ready", 32'(ir3), 32'(ordy3));
            chk("u3_occupancy", 32'(occ3), 32'd0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int k, input logic [15:0] base, input int n);
        int sent = 0;
        ordy[k] = 1'b0;
        for (int c = 0; c < 20 && sent < n; c++) begin
            iv[k] = 1'b1;
            id[k] = base + 16'(sent);
            tick();
            if (acc[k]) sent++;
        end
        iv[k] = 1'b0;
        chk("fill_count", 32'(sent), 32'(n));
    endtask

    task automatic drain(input int k);
        iv[k]   = 1'b0;
        ordy[k] = 1'b1;
        repeat (6) tick();
    endtask

    logic [15:0] got [$];
    int          sent;
    int          thr;

    initial begin
        rst   = 1'b1;
        iv    = '0;
        ordy  = '1;
        fl    = '0;
        for (int k = 0; k < 3; k++) id[k] = '0;
        iv3   = 1'b0;
        ordy3 = 1'b0;
        fl3   = 1'b0;
        id3   = '0;
        acc   = '0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        // Reset values
        @(negedge clk);
        chk("rst_out_valid", 32'(ov_d[0]), 32'd0);
        chk("rst_out_data", 32'(od_d[0]), 32'd0);
        chk("rst_occupancy", 32'(occ0), 32'd0);
        chk("rst_in_ready", 32'(ir_d[0]), 32'd1);
        tick();

        // Streaming 0x0001..0x0010 with out_ready held high
        for (int c = 0; c < 24; c++) begin
            iv[0]   = (c < 16);
            id[0]   = 16'(c + 1);
            ordy[0] = 1'b1;
            @(negedge clk);
            if (c == 3) chk("stream_not_early", 32'(ov_d[0]), 32'd0);
            if (c == 4) begin
                chk("stream_first_valid", 32'(ov_d[0]), 32'd1);
                chk("stream_first_data", 32'(od_d[0]), 32'h0001);
            end
            if (c == 8) chk("stream_occ", 32'(occ0), 32'd4);
            if (c == 19) chk("stream_last_data", 32'(od_d[0]), 32'h0010);
            tick();
        end
        iv[0] = 1'b0;

        // Backpressure: 6 words, output stalled for the first 12 cycles
        sent = 0;
        got.delete();
        for (int c = 0; c < 60 && got.size() < 6; c++) begin
            iv[0]   = (sent < 6);
            id[0]   = 16'h0101 + 16'(sent);
            ordy[0] = (c >= 12);
            @(negedge clk);
            if (c == 8) begin
                chk("bp_full_in_ready", 32'(ir_d[0]), 32'd0);
                chk("bp_full_occ", 32'(occ0), 32'd4);
            end
            if (ov_d[0] && ordy[0]) got.push_back(od_d[0]);
            tick();
            if (acc[0]) sent++;
        end
        iv[0] = 1'b0;
        chk("bp_count", 32'(got.size()), 32'd6);
        for (int i = 0; i < got.size(); i++) chk("bp_order", 32'(got[i]), 32'h0101 + 32'(i));
        drain(0);

        // Bubble collapse vs global stall, pattern 1,0,1,0 with output stalled
        ordy[0] = 1'b0;
        ordy[1] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            iv[0] = (c < 4) && (c % 2 == 0);
            iv[1] = iv[0];
            id[0] = 16'h0C00 + 16'(c);
            id[1] = id[0];
            @(negedge clk);
            if (c == 3) chk("gs_in_ready_before", 32'(ir_d[1]), 32'd1);
            if (c == 4) chk("gs_in_ready_full", 32'(ir_d[1]), 32'd0);
            if (c == 5) begin
                chk("col_occ", 32'(occ0), 32'd2);
                chk("col_in_ready", 32'(ir_d[0]), 32'd1);
                chk("col_head_valid", 32'(ov_d[0]), 32'd1);
                chk("col_head_data", 32'(od_d[0]), 32'h0C00);
            end
            tick();
        end
        drain(0);
        drain(1);

        // Full pipe with simultaneous input and output
        fill(0, 16'hD000, 4);
        for (int c = 0; c < 3; c++) begin
            iv[0]   = 1'b1;
            id[0]   = 16'hD100 + 16'(c);
            ordy[0] = 1'b1;
            @(negedge clk);
            chk("full_pass_in_ready", 32'(ir_d[0]), 32'd1);
            chk("full_pass_out_valid", 32'(ov_d[0]), 32'd1);
            chk("full_pass_occ", 32'(occ0), 32'd4);
            tick();
        end
        iv[0]   = 1'b0;
        ordy[0] = 1'b0;
        @(negedge clk);
        chk("full_after_occ", 32'(occ0), 32'd4);
        tick();
        drain(0);

        // Flush with three words in flight
        fill(0, 16'hE000, 3);
        fl[0]   = 1'b1;
        iv[0]   = 1'b1;
        id[0]   = 16'hEEEE;
        @(negedge clk);
        chk("flush_in_ready", 32'(ir_d[0]), 32'd0);
        chk("flush_occ_before", 32'(occ0), 32'd3);
        tick();
        fl[0] = 1'b0;
        iv[0] = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 32'(ov_d[0]), 32'd0);
        chk("flush_occ", 32'(occ0), 32'd0);
        tick();
        ordy[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("flush_no_emit", 32'(ov_d[0]), 32'd0);
            tick();
        end

        // DELAY=1 streaming
        ordy[2] = 1'b1;
        iv[2]   = 1'b1;
        id[2]   = 16'hAAAA;
        @(negedge clk);
        chk("d1_in_ready0", 32'(ir_d[2]), 32'd1);
        tick();
        id[2] = 16'h5555;
        @(negedge clk);
        chk("d1_in_ready1", 32'(ir_d[2]), 32'd1);
        chk("d1_out_valid0", 32'(ov_d[2]), 32'd1);
        chk("d1_out_data0", 32'(od_d[2]), 32'hAAAA);
        tick();
        iv[2] = 1'b0;
        @(negedge clk);
        chk("d1_out_data1", 32'(od_d[2]), 32'h5555);
        tick();
        @(negedge clk);
        chk("d1_empty", 32'(ov_d[2]), 32'd0);
        tick();

        // DELAY=0 combinational pass-through (flush ignored)
        iv3 = 1'b1; id3 = 16'h1234; ordy3 = 1'b0; fl3 = 1'b1;
        #1;
        chk("d0_out_valid", 32'(ov3), 32'd1);
        chk("d0_out_data", 32'(od3), 32'h1234);
        chk("d0_in_ready_lo", 32'(ir3), 32'd0);
        ordy3 = 1'b1;
        #1;
        chk("d0_in_ready_hi", 32'(ir3), 32'd1);
        iv3 = 1'b0; fl3 = 1'b0;
        #1;
        chk("d0_out_valid_lo", 32'(ov3), 32'd0);
        tick();

        // Asynchronous reset between clock edges
        fill(0, 16'hF000, 4);
        @(negedge clk);
        chk("arst_pre_valid", 32'(ov_d[0]), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(ov_d[0]), 32'd0);
        chk("arst_out_data", 32'(od_d[0]), 32'd0);
        chk("arst_occ", 32'(occ0), 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        tick();

        // Randomized traffic, upstream holds words until accepted
        for (int c = 0; c < 3000; c++) begin
            thr = (c < 1500) ? 35 : 80;
            for (int k = 0; k < 3; k++) begin
                if (!(iv[k] && !acc[k])) begin
                    iv[k] = ($urandom_range(0, 99) < 70);
                    id[k] = 16'($urandom);
                end
                ordy[k] = ($urandom_range(0, 99) < thr);
                fl[k]   = ($urandom_range(0, 99) < 3);
            end
            iv3   = 1'($urandom);
            id3   = 16'($urandom);
            ordy3 = 1'($urandom);
            fl3   = 1'($urandom);
            tick();
        end
        iv = '0;
        fl = '0;

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/delay_pipe.md
Name: delay_pipe

Overview:
Elastic, parametrised successor of the plain enable-stalled delay line in the pipelined-math library. It delays a data word by DELAY register stages and tracks a valid bit per stage. It supports valid/ready backpressure, optional bubble collapsing, synchronous flush and an occupancy count. It sits between arithmetic pipeline sections whose consumers can stall, replacing global-enable delay chains.

Parameters:
DELAY, 4, number of register stages (0 = combinational passthrough)
WIDTH, 16, data word width in bits
COLLAPSE, 1, 1 = per-stage bubble collapsing; 0 = global stall (whole chain advances together)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
flush  input  1  synchronous clear of all stage valid bits
in_valid  input  1  upstream word valid
in_ready  output  1  delay_pipe can accept in_data this cycle
in_data  input  WIDTH  upstream word
out_valid  output  1  valid of last stage
out_ready  input  1  downstream accepts out_data
out_data  output  WIDTH  data of last stage
occupancy  output  $clog2(DELAY+1) (min 1)  count of valid stages

Behaviour:
- Stages 0..DELAY-1. Each stage has v[i] and d[i]. Stage 0 is fed from in_*. Stage DELAY-1 drives out_valid=v[DELAY-1] and out_data=d[DELAY-1].
- Reset (async): all v[i]=0 and all d[i]=0. Outputs after reset: out_valid=0, out_data=0, occupancy=0, and in_ready=1 once out of reset.
- Handshake: a transfer occurs on a cycle with valid&&ready. Once in_valid is asserted, in_data is held until accepted; out_valid/out_data obey the same rule.
- COLLAPSE=1:
  - r[DELAY]=out_ready; r[i] = !v[i] || r[i+1]; in_ready = r[0].
  - When r[i]=1, stage i takes v[i-1] (in_valid for i=0). It loads d[i] only if the incoming valid is 1; otherwise it keeps its old data.
  - Bubbles are squeezed out while the output stalls.
  - Combinational path from out_ready to in_ready is accepted by design.
- COLLAPSE=0:
  - adv = out_ready || !v[DELAY-1]; in_ready = adv.
  - On adv, all stages shift by one, and v[0] = in_valid && adv.
  - No bubble removal; this is equivalent to the old en-driven delay with en=adv.
- Latency: with out_ready held at 1, a word accepted at cycle t appears at out_valid at cycle t+DELAY. Sustained throughput is 1 word/cycle in both modes.
- Full condition: all v=1 and out_ready=0 gives in_ready=0. An input presented then is not taken, and no data is lost or overwritten.
- Simultaneous: when full and out_ready=1, in_ready=1 in the same cycle (pass-through advance). Occupancy stays DELAY.
- occupancy = popcount(v), registered alongside v, valid the cycle after each update. It updates +1/-1/0 according to input and output transfers.
- flush:
  - Has priority over the handshake: next cycle all v=0 and occupancy=0.
  - in_ready reads 0 during a flush cycle; no input is accepted.
  - d[] keeps its old contents.
- rst mid-operation: in-flight words are discarded immediately and asynchronously, and outputs drop to reset values.
- DELAY=0: in_ready=out_ready, out_valid=in_valid, out_data=in_data, occupancy=0. flush is ignored.

Test Plan:
- Streaming: DELAY=4, COLLAPSE=1, out_ready=1, inputs 0x0001..0x0010 on consecutive cycles -> out_data 0x0001..0x0010 on consecutive cycles, first one 4 cycles after the first accept; occupancy steady at 4.
- Backpressure: send 6 words while out_ready=0 -> in_ready falls after the 4th accept; occupancy=4; releasing out_ready delivers all 6 in order with no duplicates or loss.
- Bubble collapse: in_valid pattern 1,0,1,0 with out_ready=0 (COLLAPSE=1) -> both words pack into stages 3,2; occupancy=2; in_ready stays 1. With COLLAPSE=0 the same stimulus -> in_ready=0 from the cycle the last stage becomes valid.
- Full with simultaneous in/out: pipe full, out_ready=1 and in_valid=1 for 3 cycles -> 3 outputs and 3 inputs accepted; occupancy stays 4.
- Flush and reset: flush with 3 words in flight -> next cycle out_valid=0, occupancy=0, none of the 3 words emitted. Async rst asserted between clock edges -> out_valid=0 and out_data=0 immediately.
- DELAY=0 and DELAY=1: DELAY=0 gives combinational equality of out_* and in_* and of in_ready and out_ready. DELAY=1 with streaming 0xAAAA,0x5555 gives 1-cycle latency and full throughput.
